// File: rtl/clock_display_driver.sv
// Six-digit multiplexed 7-segment driver for digital_clock outputs.
// Per-frame snapshot, 12h/24h, time/date pages, blink on alert.
module clock_display_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  hour,
  input  logic [5:0]  min,
  input  logic [5:0]  sec,
  input  logic [4:0]  day,
  input  logic [3:0]  month,
  input  logic [11:0] year,
  input  logic        mode_12h,
  input  logic        page_sel,
  input  logic        alarm_buzzer,
  input  logic        timer_buzzer,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        pm_led,
  output logic        frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [5:0] AN_OFF   = 6'h3F;

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic          load_pending;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [4:0]  s_hour;
  logic [5:0]  s_min;
  logic [5:0]  s_sec;
  logic [4:0]  s_day;
  logic [3:0]  s_month;
  logic [11:0] s_year;
  logic        s_12h;
  logic        s_page;
  logic        s_alert;

  logic tick;
  logic load;
  logic alert_in;

  assign tick     = (pre == PRE_MAX);
  assign load     = (tick && idx == 3'd5) || load_pending;
  assign alert_in = alarm_buzzer | timer_buzzer;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  logic       use_12h;
  logic [4:0] hour_disp;
  logic [6:0] year_lo;
  logic [6:0] fval;
  logic       fok;
  logic       blank_t;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] digit;
  logic [6:0] seg_next;
  logic [5:0] an_next;
  logic       pm_next;

  assign use_12h = s_12h && !s_page;
  assign year_lo = 7'(s_year % 12'd100);

  always_comb begin
    hour_disp = s_hour;
    if (use_12h) begin
      if (s_hour == 5'd0)
        hour_disp = 5'd12;
      else if (s_hour > 5'd12)
        hour_disp = s_hour - 5'd12;
    end
  end

  // Field select: idx 5/4 -> left pair, 3/2 -> middle, 1/0 -> right.
  always_comb begin
    fval    = '0;
    fok     = 1'b1;
    blank_t = 1'b0;
    unique case (1'b1)
      idx[2]: begin
        if (s_page) begin
          fval = {2'b00, s_day};
          fok  = (s_day != 5'd0) && (s_day <= 5'd31);
        end else begin
          fval    = {2'b00, hour_disp};
          fok     = (s_hour <= 5'd23);
          blank_t = use_12h && (hour_disp < 5'd10);
        end
      end
      idx[1]: begin
        if (s_page) begin
          fval = {3'b000, s_month};
          fok  = (s_month != 4'd0) && (s_month <= 4'd12);
        end else begin
          fval = {1'b0, s_min};
          fok  = (s_min <= 6'd59);
        end
      end
      default: begin
        if (s_page) begin
          fval = year_lo;
        end else begin
          fval = {1'b0, s_sec};
          fok  = (s_sec <= 6'd59);
        end
      end
    endcase
  end

  assign tens  = 4'(fval / 7'd10);
  assign ones  = 4'(fval % 7'd10);
  assign digit = idx[0] ? tens : ones;

  always_comb begin
    seg_next = enc(digit);
    if (!fok)
      seg_next = SEG_DASH;
    else if (idx[0] && blank_t)
      seg_next = SEG_OFF;
  end

  assign an_next = ~(6'd1 << idx);
  assign pm_next = use_12h && (s_hour >= 5'd12);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      s_hour       <= '0;
      s_min        <= '0;
      s_sec        <= '0;
      s_day        <= '0;
      s_month      <= '0;
      s_year       <= '0;
      s_12h        <= 1'b0;
      s_page       <= 1'b0;
      s_alert      <= 1'b0;
      seg          <= SEG_OFF;
      an           <= AN_OFF;
      pm_led       <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + 1'b1;
      frame_start <= load;
      if (tick)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (load) begin
        load_pending <= 1'b0;
        s_hour       <= hour;
        s_min        <= min;
        s_sec        <= sec;
        s_day        <= day;
        s_month      <= month;
        s_year       <= year;
        s_12h        <= mode_12h;
        s_page       <= page_sel;
        s_alert      <= alert_in;
        // Counter holds frames already spent in the current phase.
        if (!alert_in) begin
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
          blink_cnt   <= BW'(1);
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (tick) begin
        if (blink_phase) begin
          seg    <= SEG_OFF;
          an     <= AN_OFF;
          pm_led <= 1'b0;
        end else begin
          seg    <= seg_next;
          an     <= an_next;
          pm_led <= pm_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver.
// Frames are queued by stimulus, checked digit by digit by a monitor.
module tb_clock_display_driver;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;
  logic        mode_12h;
  logic        page_sel;
  logic        alarm_buzzer;
  logic        timer_buzzer;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic        pm_led;
  logic        frame_start;

  clock_display_driver #(
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hour        (hour),
    .min         (min),
    .sec         (sec),
    .day         (day),
    .month       (month),
    .year        (year),
    .mode_12h    (mode_12h),
    .page_sel    (page_sel),
    .alarm_buzzer(alarm_buzzer),
    .timer_buzzer(timer_buzzer),
    .seg         (seg),
    .an          (an),
    .pm_led      (pm_led),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0][6:0] seg;
    logic            pm;
    logic            dark;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   busy = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] s5, input logic [6:0] s4,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic pm);
    exp_t e;
    e.seg[5] = s5;
    e.seg[4] = s4;
    e.seg[3] = s3;
    e.seg[2] = s2;
    e.seg[1] = s1;
    e.seg[0] = s0;
    e.pm     = pm;
    e.dark   = 1'b0;
    return e;
  endfunction

  function automatic exp_t dk();
    exp_t e;
    e      = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    e.dark = 1'b1;
    return e;
  endfunction

  // Monitor: a frame's digit k is visible SD*(k+1) cycles after frame_start.
  initial begin
    bit   carry;
    exp_t e;
    logic [5:0] ea;
    carry = 0;
    forever begin
      if (!carry) begin
        @(negedge clk);
        if (!frame_start) continue;
      end
      carry = 0;
      if (q.size() == 0) continue;
      e    = q.pop_front();
      busy = 1;
      for (int k = 0; k < 6; k++) begin
        repeat (SD) @(negedge clk);
        ea = e.dark ? 6'h3F : ~(6'd1 << k);
        chk($sformatf("digit%0d", k), {15'd0, pm_led, an, seg},
            {15'd0, e.pm, ea, e.seg[k]});
      end
      busy  = 0;
      carry = frame_start;
    end
  end

  task automatic next_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    if (!frame_start) chk("frame_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m,
                          input logic [5:0] s);
    page_sel = 1'b0;
    hour     = h;
    min      = m;
    sec      = s;
  endtask

  exp_t t_base;
  int   n;

  initial begin
    t_base = mk(7'h79, 7'h30, 7'h40, 7'h12, 7'h40, 7'h10, 1'b0);
    reset = 1'b1;
    set_time(5'd13, 6'd5, 6'd9);
    day = 5'd1;
    month = 4'd1;
    year = 12'd2000;
    mode_12h = 1'b0;
    alarm_buzzer = 1'b0;
    timer_buzzer = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {26'd0, an}, 32'h3F);
    chk("rst_pm", {31'd0, pm_led}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;

    next_frame(n);
    chk("first_load_delay", n, 32'd1);
    q.push_back(t_base);
    next_frame(n);
    chk("first_frame_len", n, 32'd23);
    mode_12h = 1'b1;
    q.push_back(mk(7'h7F, 7'h79, 7'h40, 7'h12, 7'h40, 7'h10, 1'b1));
    next_frame(n);
    chk("frame_len", n, 32'd24);
    hour = 5'd0;
    q.push_back(mk(7'h79, 7'h24, 7'h40, 7'h12, 7'h40, 7'h10, 1'b0));
    next_frame(n);
    hour = 5'd12;
    q.push_back(mk(7'h79, 7'h24, 7'h40, 7'h12, 7'h40, 7'h10, 1'b1));
    next_frame(n);
    page_sel = 1'b1;
    day = 5'd7;
    month = 4'd12;
    year = 12'd2025;
    q.push_back(mk(7'h40, 7'h78, 7'h79, 7'h24, 7'h24, 7'h12, 1'b0));
    next_frame(n);
    mode_12h = 1'b0;
    set_time(5'd13, 6'd5, 6'd9);
    q.push_back(t_base);
    next_frame(n);
    q.push_back(mk(7'h79, 7'h30, 7'h40, 7'h12, 7'h79, 7'h40, 1'b0));
    repeat (2) @(negedge clk);
    sec = 6'd10;
    next_frame(n);
    hour = 5'd25;
    q.push_back(mk(7'h3F, 7'h3F, 7'h40, 7'h12, 7'h79, 7'h40, 1'b0));
    next_frame(n);
    set_time(5'd23, 6'd60, 6'd59);
    q.push_back(mk(7'h24, 7'h30, 7'h3F, 7'h3F, 7'h12, 7'h10, 1'b0));
    next_frame(n);
    page_sel = 1'b1;
    day = 5'd31;
    month = 4'd0;
    year = 12'd1999;
    q.push_back(mk(7'h30, 7'h79, 7'h3F, 7'h3F, 7'h10, 7'h10, 1'b0));
    next_frame(n);

    set_time(5'd13, 6'd5, 6'd9);
    alarm_buzzer = 1'b1;
    q.push_back(t_base);
    next_frame(n);
    q.push_back(t_base);
    next_frame(n);
    q.push_back(dk());
    next_frame(n);
    q.push_back(dk());
    next_frame(n);
    q.push_back(t_base);
    next_frame(n);
    q.push_back(t_base);
    next_frame(n);
    alarm_buzzer = 1'b0;
    q.push_back(t_base);
    next_frame(n);
    timer_buzzer = 1'b1;
    q.push_back(t_base);
    next_frame(n);
    q.push_back(t_base);
    next_frame(n);
    q.push_back(dk());
    next_frame(n);
    timer_buzzer = 1'b0;
    q.push_back(t_base);
    next_frame(n);

    n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {31'd0, (q.size() == 0 && !busy)}, 32'd1);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an != 6'h37 && n < 200);
    chk("reach_digit3", {26'd0, an}, 32'h37);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_an", {26'd0, an}, 32'h3F);
    chk("mid_rst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fs", {31'd0, frame_start}, 32'd1);
    chk("post_rst_an", {26'd0, an}, 32'h3F);
    repeat (2) @(negedge clk);
    chk("pre_tick_an", {26'd0, an}, 32'h3F);
    @(negedge clk);
    chk("first_digit_an", {26'd0, an}, 32'h3E);
    chk("first_digit_seg", {25'd0, seg}, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_display_driver.md
Name: clock_display_driver

Overview:
- Downstream consumer of digital_clock; turns its binary hour/min/sec/day/month/year outputs into a multiplexed 6-digit active-low 7-segment display.
- Snapshots inputs once per scan frame so a frame never mixes two clock values (no tearing).
- Supports 12h/24h formatting, a time/date page, and display blinking while any buzzer is active.

Parameters:
- SCAN_DIV, 1000, system clocks per digit slot (≥2).
- BLINK_FRAMES, 32, full scan frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hour  in  5  0..23 from digital_clock.
- min  in  6  0..59.
- sec  in  6  0..59.
- day  in  5  1..31.
- month  in  4  1..12.
- year  in  12  full year.
- mode_12h  in  1  1 = 12h format with PM indicator; 0 = 24h.
- page_sel  in  1  0 = time HH MM SS; 1 = date DD MM YY.
- alarm_buzzer  in  1  alert source.
- timer_buzzer  in  1  alert source.
- seg  out  7  active-low segments, bit6..0 = g f e d c b a.
- an  out  6  active-low digit enables; an[0] = rightmost digit.
- pm_led  out  1  PM indicator for the displayed frame.
- frame_start  out  1  one-cycle pulse when a new snapshot is latched.

Behaviour:
- Reset: seg=7'h7F, an=6'h3F, pm_led=0, frame_start=0, prescaler=0, digit index=0, blink counter=0, blink phase=0, snapshot cleared, load_pending=1.
- Prescaler:
  - counts 0..SCAN_DIV-1, then wraps.
  - tick = (count == SCAN_DIV-1).
  - digit index advances on tick, 0→5, then wraps 5→0.
- Snapshot:
  - latch all inputs, mode_12h, page_sel, and alert = alarm_buzzer|timer_buzzer when (tick && index==5) or load_pending.
  - load_pending clears after its load (first cycle after reset).
  - frame_start pulses in the cycle the snapshot is latched.
  - Input changes mid-frame do not affect the displayed frame.
- Digit values, from the snapshot:
  - page 0 digits 5..0: hour tens/ones, min tens/ones, sec tens/ones.
  - page 1 digits 5..0: day, month, year%100.
  - tens = v/10, ones = v%10 (combinational).
- 12h (page 0 only): displayed hour = 12 if hour==0; hour-12 if hour>12; else hour.
  - pm_led = (hour>=12).
  - hour tens digit blanked (7'h7F) when 0.
  - In 24h, or on page 1: pm_led=0 and no blanking.
- Out of range: hour>23, min>59, or sec>59 displays both digits of that field as dash (7'b0111111). Same for day 0 or >31 and month 0 or >12. The year field never shows dashes.
- Encoding, digits 0-9 in order: 40,79,24,30,19,12,02,78,00,10 (hex).
- Outputs: an/seg are registered and update one cycle after the tick or snapshot that selects them. Exactly one an bit is low at a time unless blanked.
- Blink:
  - blink counter increments per snapshot while alert=1.
  - at BLINK_FRAMES it resets and toggles blink phase.
  - phase=1 forces an=6'h3F and seg=7'h7F.
  - A snapshot with alert=0 clears the counter and phase.
  - pm_led is also blanked in phase 1.
- Reset mid-frame: everything returns to reset values next cycle; snapshot reloaded the following cycle.

Test Plan:
- SCAN_DIV=4, hour=13 min=5 sec=9, mode_12h=0, page 0:
  - digits 5..0 show 1,3,0,5,0,9, seg 79,30,40,12,40,10.
  - an cycles 3E,3D,3B,37,2F,1F, each held 4 clocks.
  - frame_start pulses once per 24 clocks.
- Same time with mode_12h=1 → hour shows blank,1 and pm_led=1.
- hour=0 in 12h → hour shows 1,2 and pm_led=0.
- hour=12 in 12h → hour shows 1,2 and pm_led=1.
- page 1, day=7 month=12 year=2025 → digits 0,7,1,2,2,5 and pm_led=0.
- Change sec from 9 to 10 mid-frame → current frame still shows 0,9; next frame shows 1,0.
- hour=25 → dashes on digits 5,4.
- BLINK_FRAMES=2, alarm_buzzer=1:
  - two frames normal, two frames dark (an=3F), then repeats.
  - Drop alarm_buzzer → next frame normal, counters cleared.
- Assert reset for one cycle mid-digit-3 → next cycle seg=7F, an=3F, index 0.
  - frame_start pulses the following cycle.
  - First digit shows after the first tick.
